// File: rtl/fifo.sv
// 32 x 8 FIFO storage array with an externally managed write/read pointer pair.
// Synchronous write, registered read (read-before-write on same-address collision).
module fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PTR_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [PTR_WIDTH-1:0]  ptr_in,
   input  logic [PTR_WIDTH-1:0]  ptr_out,
   input  logic                  en_write,
   input  logic                  en_read,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int unsigned Depth = 1 << PTR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [Depth];
   logic [DATA_WIDTH-1:0] r_data_out;

   // Nonblocking read of r_mem yields the pre-write contents on a same-address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (en_write) begin
         r_mem[ptr_in] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out <= '0;
      end else if (en_read) begin
         r_data_out <= r_mem[ptr_out];
      end
   end

   assign data_out = r_data_out;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: directed test-plan sequences followed by random traffic,
// checked against an array model of the storage and its read/reset semantics.
module tb_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = '0;
   logic [4:0] ptr_in = '0;
   logic [4:0] ptr_out = '0;
   logic       en_write = 1'b0;
   logic       en_read = 1'b0;
   logic [7:0] data_out;

   fifo #(
      .DATA_WIDTH(8),
      .PTR_WIDTH (5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .ptr_in  (ptr_in),
      .ptr_out (ptr_out),
      .en_write(en_write),
      .en_read (en_read),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   logic [7:0] model_mem [32];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   // Drive one edge worth of inputs and record what the output must become.
   task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [7:0] wd, input logic re, input logic [4:0] ra);
      @(negedge clk);
      reset    = rst;
      en_write = we;
      ptr_in   = wa;
      data_in  = wd;
      en_read  = re;
      ptr_out  = ra;
      if (rst) begin
         foreach (model_mem[i]) model_mem[i] = 8'h00;
         exp_q.push_back(8'h00);
      end else begin
         if (re) exp_q.push_back(model_mem[ra]);
         if (we) model_mem[wa] = wd;
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      step(1'b0, 1'b1, a, d, 1'b0, 5'd0);
   endtask

   task automatic rd(input logic [4:0] a);
      step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, a);
   endtask

   // Monitor: every edge after the first reset, data_out must equal the latest
   // expected value (newly popped on a read/reset edge, otherwise held).
   logic       mon_active = 1'b0;
   logic [7:0] cur_exp = '0;
   always @(posedge clk) begin
      logic upd;
      upd = reset | en_read;
      #1;
      if (reset) mon_active = 1'b1;
      if (mon_active) begin
         if (upd) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard_underflow: queue empty at time %0t, data_out=%02h",
                        $time, data_out);
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         n_checks++;
         if (data_out !== cur_exp) begin
            n_errors++;
            $display("FAIL data_out(%s) at %0t: got %02h expected %02h",
                     upd ? "read" : "hold", $time, data_out, cur_exp);
         end
      end
   end

   initial begin
      foreach (model_mem[i]) model_mem[i] = 8'h00;

      // Reset then idle; reads of unwritten entries return 0
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
      idle();
      rd(5'd0);
      rd(5'd17);

      // Single write/read, value held after en_read drops
      wr(5'd1, 8'h0A);
      idle();
      idle();
      rd(5'd1);
      idle();
      idle();

      // Back-to-back writes, sequential reads
      wr(5'd2, 8'h0A);
      wr(5'd3, 8'h1B);
      rd(5'd2);
      rd(5'd3);

      // Burst, hold en_write on address 9, concurrent read of 4
      wr(5'd4, 8'h0A);
      wr(5'd5, 8'h1B);
      wr(5'd6, 8'h2C);
      wr(5'd7, 8'h0A);
      wr(5'd8, 8'h1B);
      wr(5'd9, 8'h2C);
      wr(5'd9, 8'h2C);
      step(1'b0, 1'b1, 5'd9, 8'h2C, 1'b1, 5'd4);
      rd(5'd9);

      // Alternating writes and reads
      wr(5'd10, 8'h0A);
      rd(5'd5);
      wr(5'd11, 8'h1B);
      rd(5'd6);

      // Same-address collision: old contents first, new data next read
      step(1'b0, 1'b1, 5'd12, 8'h55, 1'b1, 5'd12);
      rd(5'd12);

      // Reset with both enables high discards write and read
      step(1'b1, 1'b1, 5'd13, 8'h77, 1'b1, 5'd12);
      for (int a = 0; a < 32; a++) rd(a[4:0]);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 31)), 8'($urandom),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      end
      for (int a = 0; a < 32; a++) rd(a[4:0]);

      idle();
      idle();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
